// File: rtl/upload_reader.sv
// upload_reader
// Serves hps_io upload reads (NVRAM / hiscore save) from a core RAM that is
// shared with the core CPU. The CPU is asked to pause while an upload session
// is active. Each read is issued to the RAM only after the core acknowledges
// the pause. The returned byte is held on ioctl_din until the next read
// completes.
//
// Ports
//   clk_sys      : system clock
//   reset_n      : synchronous, active-low reset
//   ioctl_upload : hps_io upload session active
//   ioctl_rd     : one-cycle read strobe from hps_io
//   ioctl_addr   : byte address of the read (25 bits)
//   ioctl_din    : read data returned to hps_io
//   ioctl_wait   : high while a read is outstanding
//   cpu_pause    : request for the core CPU to halt RAM access
//   pause_ack    : core confirms the CPU is halted
//   ram_addr     : RAM read address
//   ram_rd       : one-cycle RAM read enable
//   ram_q        : RAM read data
module upload_reader #(
  parameter int ADDR_W  = 10,
  parameter int SIZE    = 1024,
  parameter int RAM_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              cpu_pause,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_ISSUE    = 3'd2,
    S_LAT      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // The range check uses the full 25-bit address so that high address bits
  // never alias into the RAM.
  localparam logic [24:0] SIZE_W   = 25'(SIZE);
  localparam logic [1:0]  LAT_LAST = 2'(RAM_LAT - 1);

  state_t              state_r;
  logic [24:0]         cap_r;
  logic                oor_r;
  logic [1:0]          cnt_r;
  logic [7:0]          din_r;
  logic                wait_r;
  logic                pause_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                rd_r;
  logic                in_range_s;

  assign in_range_s = (cap_r < SIZE_W);

  assign ioctl_din  = din_r;
  assign ioctl_wait = wait_r;
  assign cpu_pause  = pause_r;
  assign ram_addr   = addr_r;
  assign ram_rd     = rd_r;

  // Read sequencer: pause tracking, address capture, RAM issue and data return.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      cap_r   <= 25'd0;
      oor_r   <= 1'b0;
      cnt_r   <= 2'd0;
      din_r   <= 8'h00;
      wait_r  <= 1'b0;
      pause_r <= 1'b0;
      addr_r  <= '0;
      rd_r    <= 1'b0;
    end else begin
      // cpu_pause follows the upload flag one cycle late, so the RAM is
      // never read in a cycle where the pause request is low.
      pause_r <= ioctl_upload;
      // ram_rd is a single-cycle pulse; only ISSUE raises it.
      rd_r    <= 1'b0;
      if (!ioctl_upload) begin
        // Session ended: drop any outstanding read, keep the last data.
        state_r <= S_IDLE;
        wait_r  <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (ioctl_rd) begin
              cap_r   <= ioctl_addr;
              wait_r  <= 1'b1;
              state_r <= pause_ack ? S_ISSUE : S_WAIT_ACK;
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_WAIT_ACK: begin
            if (pause_ack) begin
              state_r <= S_ISSUE;
            end else begin
              state_r <= S_WAIT_ACK;
            end
          end
          S_ISSUE: begin
            if (in_range_s) begin
              rd_r    <= 1'b1;
              addr_r  <= cap_r[ADDR_W-1:0];
              cnt_r   <= 2'd0;
              oor_r   <= 1'b0;
              state_r <= S_LAT;
            end else begin
              // Out of range: no RAM access, 0xFF is returned from DONE.
              oor_r   <= 1'b1;
              state_r <= S_DONE;
            end
          end
          S_LAT: begin
            // Pause acknowledge is deliberately ignored here; once the
            // read is issued it always completes.
            if (cnt_r == LAT_LAST) begin
              state_r <= S_DONE;
            end else begin
              cnt_r   <= cnt_r + 2'd1;
            end
          end
          S_DONE: begin
            din_r   <= oor_r ? 8'hFF : ram_q;
            wait_r  <= 1'b0;
            state_r <= S_IDLE;
          end
          default: begin
            wait_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_upload_reader.sv
// Directed bench for upload_reader: one instance with RAM_LAT=1 for the
// functional and boundary cases, one with RAM_LAT=2 for full-range streaming.
module tb_upload_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        up_a, rd_a, ack_a;
  logic [24:0] addr_a;
  logic [7:0]  din_a, q_a;
  logic        wait_a, pause_a, ramrd_a;
  logic [9:0]  ramaddr_a;

  logic        up_b, rd_b, ack_b;
  logic [24:0] addr_b;
  logic [7:0]  din_b, q_b, s1_b;
  logic        wait_b, pause_b, ramrd_b;
  logic [9:0]  ramaddr_b;

  logic [7:0]  mem [0:1023];
  logic [7:0]  exp_q [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_cyc_a = 0;
  int pulses_a = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  upload_reader #(.ADDR_W(10), .SIZE(1024), .RAM_LAT(1)) u_a (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_upload(up_a), .ioctl_rd(rd_a),
    .ioctl_addr(addr_a), .ioctl_din(din_a), .ioctl_wait(wait_a),
    .cpu_pause(pause_a), .pause_ack(ack_a), .ram_addr(ramaddr_a),
    .ram_rd(ramrd_a), .ram_q(q_a)
  );

  upload_reader #(.ADDR_W(10), .SIZE(1024), .RAM_LAT(2)) u_b (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_upload(up_b), .ioctl_rd(rd_b),
    .ioctl_addr(addr_b), .ioctl_din(din_b), .ioctl_wait(wait_b),
    .cpu_pause(pause_b), .pause_ack(ack_b), .ram_addr(ramaddr_b),
    .ram_rd(ramrd_b), .ram_q(q_b)
  );

  function automatic logic [7:0] exp_byte(input int a);
    if (a == 18) return 8'h5A;
    return 8'(a * 37 + 11) ^ 8'(a >> 3);
  endfunction

  // RAM models: one-cycle and two-cycle read latency
  always @(posedge clk) begin
    if (ramrd_a) q_a <= mem[ramaddr_a];
    if (ramrd_b) s1_b <= mem[ramaddr_b];
    q_b <= s1_b;
  end

  // cycle counter, advanced on each active edge
  always @(posedge clk) cyc++;

  // ram_rd rules: single-cycle pulses, only while cpu_pause is high
  always @(negedge clk) begin
    if (ramrd_a === 1'b1) begin
      pulses_a++;
      rd_cyc_a = cyc;
      total++;
      assert (prev_a === 1'b0 && pause_a === 1'b1) else begin
        bad++;
        $error("FAIL ram_rd_rule_a observed prev=%b pause=%b required prev=0 pause=1", prev_a, pause_a);
      end
    end
    if (ramrd_b === 1'b1) begin
      total++;
      assert (prev_b === 1'b0 && pause_b === 1'b1) else begin
        bad++;
        $error("FAIL ram_rd_rule_b observed prev=%b pause=%b required prev=0 pause=1", prev_b, pause_b);
      end
    end
    prev_a = ramrd_a;
    prev_b = ramrd_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_wait"},   32'(wait_a),    32'd0);
    chk({tag, "_pause"},  32'(pause_a),   32'd0);
    chk({tag, "_ram_rd"}, 32'(ramrd_a),   32'd0);
    chk({tag, "_addr"},   32'(ramaddr_a), 32'd0);
    chk({tag, "_din"},    32'(din_a),     32'h00);
  endtask

  // One read on instance A. exp_m = edges after the strobe edge until
  // ioctl_wait is seen low with valid data.
  task automatic read_a(input logic [24:0] a, input int ack_low, input int exp_m,
                        input bit in_rng, input bit poke, input bit drop_ack);
    int j;
    int n0;
    int p0;
    logic [7:0] e;
    @(negedge clk);
    addr_a = a;
    rd_a   = 1'b1;
    if (ack_low > 0) ack_a = 1'b0;
    exp_q.push_back(in_rng ? exp_byte(int'(a)) : 8'hFF);
    p0 = pulses_a;
    @(negedge clk);
    rd_a = 1'b0;
    n0   = cyc;
    j    = 0;
    chk("wait_rise", 32'(wait_a), 32'd1);
    while (wait_a === 1'b1 && j < 100) begin
      if (j == ack_low - 1) ack_a = 1'b1;
      if (poke && j == 1) begin
        rd_a   = 1'b1;
        addr_a = a + 25'd1;
      end
      if (poke && j == 2) rd_a = 1'b0;
      if (drop_ack && j == 1) ack_a = 1'b0;
      @(negedge clk);
      j++;
    end
    ack_a = 1'b1;
    rd_a  = 1'b0;
    chk("latency", 32'(j), 32'(exp_m));
    e = exp_q.pop_front();
    chk("data", 32'(din_a), 32'(e));
    chk("ram_rd_count", 32'(pulses_a - p0), 32'(in_rng));
    if (in_rng) chk("ram_rd_time", 32'(rd_cyc_a - n0), 32'(1 + ack_low));
    if (poke) begin
      repeat (2) @(negedge clk);
      chk("no_queue_wait", 32'(wait_a), 32'd0);
      chk("no_queue_count", 32'(pulses_a - p0), 32'd1);
    end
  endtask

  initial begin
    int j;
    logic [7:0] e;
    for (int i = 0; i < 1024; i++) mem[i] = exp_byte(i);
    reset_n = 1'b0;
    up_a = 1'b0; rd_a = 1'b0; ack_a = 1'b0; addr_a = 25'd0;
    up_b = 1'b0; rd_b = 1'b0; ack_b = 1'b0; addr_b = 25'd0;
    repeat (3) @(negedge clk);
    chk_reset_a("reset");
    chk("reset_din_b", 32'(din_b), 32'h00);

    reset_n = 1'b1;
    up_a  = 1'b1;
    ack_a = 1'b1;
    @(negedge clk);
    chk("pause_rise", 32'(pause_a), 32'd1);

    read_a(25'h12, 0, 3, 1'b1, 1'b0, 1'b0);        // basic read, 0x5A
    read_a(25'h400, 0, 2, 1'b0, 1'b0, 1'b0);       // first out-of-range address
    read_a(25'h3FF, 0, 3, 1'b1, 1'b0, 1'b0);       // last in-range address
    read_a(25'h1FFFFFF, 0, 2, 1'b0, 1'b0, 1'b0);   // high bits set
    read_a(25'h155, 5, 8, 1'b1, 1'b0, 1'b0);       // delayed acknowledge
    read_a(25'h2A, 0, 3, 1'b1, 1'b1, 1'b0);        // strobe while busy
    read_a(25'h77, 0, 3, 1'b1, 1'b0, 1'b1);        // ack drops during LAT

    // strobe with no upload session is ignored
    @(negedge clk);
    up_a = 1'b0;
    @(negedge clk);
    chk("pause_fall", 32'(pause_a), 32'd0);
    rd_a = 1'b1;
    addr_a = 25'h5;
    @(negedge clk);
    rd_a = 1'b0;
    chk("no_session_wait", 32'(wait_a), 32'd0);
    @(negedge clk);
    chk("no_session_ram_rd", 32'(ramrd_a), 32'd0);
    chk("no_session_din", 32'(din_a), 32'(exp_byte(32'h77)));

    // abort during LAT
    up_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b1;
    addr_a = 25'h20;
    @(negedge clk);
    rd_a = 1'b0;
    @(negedge clk);
    chk("abort_ram_rd_issued", 32'(ramrd_a), 32'd1);
    up_a = 1'b0;
    @(negedge clk);
    chk("abort_wait", 32'(wait_a), 32'd0);
    chk("abort_ram_rd", 32'(ramrd_a), 32'd0);
    chk("abort_pause", 32'(pause_a), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_din_kept", 32'(din_a), 32'(exp_byte(32'h77)));
    chk("abort_wait_idle", 32'(wait_a), 32'd0);
    up_a = 1'b1;
    read_a(25'h21, 0, 3, 1'b1, 1'b0, 1'b0);        // recovery after abort

    // reset while waiting for the acknowledge
    @(negedge clk);
    ack_a = 1'b0;
    rd_a = 1'b1;
    addr_a = 25'h33;
    @(negedge clk);
    rd_a = 1'b0;
    chk("wait_ack_wait", 32'(wait_a), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_a("mid_reset");
    reset_n = 1'b1;
    ack_a = 1'b1;
    read_a(25'h12, 0, 3, 1'b1, 1'b0, 1'b0);        // first read after reset

    // streaming all addresses through the two-cycle latency instance
    up_b  = 1'b1;
    ack_b = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 1024; a++) begin
      rd_b = 1'b1;
      addr_b = 25'(a);
      exp_q.push_back(mem[a]);
      @(negedge clk);
      rd_b = 1'b0;
      j = 0;
      while (wait_b === 1'b1 && j < 100) begin
        @(negedge clk);
        j++;
      end
      chk("stream_latency", 32'(j), 32'd4);
      e = exp_q.pop_front();
      chk("stream_data", 32'(din_b), 32'(e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/upload_reader.md
UPLOAD_READER -- requirements
Module: upload_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: width of the core NVRAM/hiscore RAM address.
REQ-002 SHALL have parameter SIZE, default 1024: number of valid bytes served; addresses >= SIZE are out of range.
REQ-003 SHALL have parameter RAM_LAT, default 1: cycles from ram_rd to valid ram_q, legal range 1-3.
REQ-004 SHALL have one clock and synchronous active-low reset (already decided), ports clk_sys and reset_n.
REQ-005 SHALL have port clk_sys, input, 1: system clock.
REQ-006 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port ioctl_upload, input, 1: hps_io upload session active.
REQ-008 SHALL have port ioctl_rd, input, 1: one-cycle read strobe from hps_io.
REQ-009 SHALL have port ioctl_addr, input, 25: byte address of the read.
REQ-010 SHALL have port ioctl_din, output, 8: read data returned to hps_io.
REQ-011 SHALL have port ioctl_wait, output, 1: high while a read is outstanding.
REQ-012 SHALL have port cpu_pause, output, 1: request for the core CPU to halt RAM access.
REQ-013 SHALL have port pause_ack, input, 1: core confirms the CPU is halted.
REQ-014 SHALL have port ram_addr, output, ADDR_W: RAM read address.
REQ-015 SHALL have port ram_rd, output, 1: one-cycle RAM read enable.
REQ-016 SHALL have port ram_q, input, 8: RAM read data.

Function
REQ-017 SHALL implement the FSM IDLE, WAIT_ACK, ISSUE, LAT, and DONE.
REQ-018 SHALL register cpu_pause as ioctl_upload delayed one cycle; it SHALL fall one cycle after ioctl_upload falls.
REQ-019 In IDLE, on ioctl_rd=1 with ioctl_upload=1, SHALL capture ioctl_addr and set ioctl_wait=1 on the next edge.
REQ-020 From IDLE, SHALL go to ISSUE if pause_ack=1, else to WAIT_ACK.
REQ-021 In IDLE, SHALL ignore ioctl_rd when ioctl_upload=0.
REQ-022 WAIT_ACK SHALL hold until pause_ack=1, then go to ISSUE, with no timeout.
REQ-023 ISSUE SHALL last one cycle, driving ram_rd=1 and ram_addr=captured[ADDR_W-1:0], when captured < SIZE.
REQ-024 When captured >= SIZE (full 25-bit compare), ISSUE SHALL keep ram_rd=0 and load 0xFF for return.
REQ-025 LAT SHALL count RAM_LAT cycles after the ram_rd cycle, then sample ram_q into the ioctl_din register.
REQ-026 Out-of-range reads SHALL skip LAT.
REQ-027 DONE SHALL last one cycle, clear ioctl_wait, and return to IDLE.
REQ-028 ioctl_din SHALL hold its value until the next capture.
REQ-029 Latency, with pause_ack already high and ioctl_rd at edge N:
- ram_rd at N+1;
- ioctl_din valid and ioctl_wait=0 at N+2+RAM_LAT.
REQ-030 Latency for an out-of-range read SHALL be ioctl_din=0xFF at N+2.
REQ-031 ioctl_rd while not in IDLE SHALL be ignored; no queueing.
REQ-032 ioctl_upload falling in any state SHALL abort to IDLE on the next edge:
- ioctl_wait=0;
- ram_rd=0;
- ioctl_din unchanged.
REQ-033 pause_ack falling during LAT SHALL NOT abort the read; the read SHALL complete.
REQ-034 ram_rd SHALL never be high for more than one consecutive cycle.
REQ-035 ram_rd SHALL never be high while cpu_pause=0.

Reset
REQ-036 reset_n=0 at an edge SHALL force IDLE and set ioctl_wait=0, cpu_pause=0, ram_rd=0, ram_addr=0, ioctl_din=0x00.
REQ-037 Reset SHALL take priority over all inputs, including mid-read and in WAIT_ACK.
REQ-038 The first ioctl_rd SHALL be accepted on the edge after reset_n returns high.

Verification
REQ-039 Basic read: RAM_LAT=1, ram[0x012]=0x5A, pause_ack=1, ioctl_rd at addr 0x12 -> ram_rd at +1, ioctl_din=0x5A and wait=0 at +3.
REQ-040 Out-of-range read: addr 0x400 with SIZE=1024 -> no ram_rd, ioctl_din=0xFF at +2.
REQ-041 Delayed acknowledge: pause_ack low for 5 cycles after the read -> wait held 5 extra cycles, data correct afterwards.
REQ-042 Abort: ioctl_upload drops during LAT -> IDLE, wait=0 next edge, cpu_pause=0 one cycle later.
REQ-043 Back-to-back streaming: sequential reads of addresses 0-1023 with RAM_LAT=2 -> every byte matches RAM, ram_rd never asserted twice in a row.
REQ-044 Reset mid-read: reset_n low in WAIT_ACK -> all outputs at their reset values on the next edge.
